// File: rtl/id_inst_queue.sv
// ---------------------------------------------------------------------------
// id_inst_queue
// IF-to-ID instruction buffer. Replaces the single-entry IF/ID register with
// a DEPTH-entry FIFO of {pc, pc4, inst} entries. The head entry is presented
// to decode first-word-fall-through. The queue also runs the load-use hazard
// check on the head entry's source registers and holds the pop on a hazard.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   flush             synchronous discard of every entry (redirect)
//   in_valid/in_ready fetch-side handshake; in_ready = !full
//   in_pc/pc4/inst    fetched entry
//   stall             downstream stall, head must not pop
//   is_load, load_rd  load currently in EX and its destination register
//   has_rs1/2/3       head instruction reads rs1/rs2/rs3
//   out_valid, out_*  head entry, forced to 0 when the queue is empty
//   load_stall        head blocked by a load-use hazard
//   pop               head consumed this cycle
//   count/empty/full  occupancy
// ---------------------------------------------------------------------------
module id_inst_queue #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int DEPTH      = 4,
    localparam int RW        = $clog2(REG_NUM),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_pc4,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic                  stall,
    input  logic                  is_load,
    input  logic [RW-1:0]         load_rd,
    input  logic                  has_rs1,
    input  logic                  has_rs2,
    input  logic                  has_rs3,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc4,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  load_stall,
    output logic                  pop,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [ADDR_WIDTH-1:0] pc4_mem  [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rs3;
    logic          hit;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready & !flush;

    assign out_pc   = empty ? '0 : pc_mem[rd_ptr];
    assign out_pc4  = empty ? '0 : pc4_mem[rd_ptr];
    assign out_inst = empty ? '0 : inst_mem[rd_ptr];

    // Source register fields of the head instruction (rs3 is the R4-type field).
    assign rs1 = out_inst[15 +: RW];
    assign rs2 = out_inst[20 +: RW];
    assign rs3 = out_inst[27 +: RW];

    assign hit = (has_rs1 & (rs1 == load_rd)) |
                 (has_rs2 & (rs2 == load_rd)) |
                 (has_rs3 & (rs3 == load_rd));

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_stall = out_valid & is_load & (load_rd != '0) & hit;
    assign pop        = out_valid & !stall & !load_stall & !flush;

    // Storage carries no reset; entries are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            pc4_mem[wr_ptr]  <= in_pc4;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Explicit wrap compare so non-power-of-two depths work.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised IF-to-ID buffer. It is the next generation of the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions as {pc, pc4, inst} entries. Presents the head entry to decode first-word-fall-through.
- Performs the load-use hazard check on the head entry's source registers and stalls the pop itself.
- Sits between stage_if and the decode/register-read logic. Decouples fetch from ID stalls.

Parameters:
ADDR_WIDTH, 64, width of pc and pc4
INST_WIDTH, 32, instruction word width
REG_NUM, 32, architectural register count; RW = $clog2(REG_NUM)
DEPTH, 4, queue entries (>=2, any integer, need not be a power of two)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous discard of all entries (branch/jump redirect)
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue accepts an entry this cycle
in_pc  in  ADDR_WIDTH  fetched pc
in_pc4  in  ADDR_WIDTH  fetched pc+4
in_inst  in  INST_WIDTH  fetched instruction
stall  in  1  downstream (EX/global) stall; head must not pop
is_load  in  1  instruction in EX is a load
load_rd  in  RW  destination of that load
has_rs1  in  1  head instruction reads rs1 = inst[19:15]
has_rs2  in  1  head reads rs2 = inst[24:20]
has_rs3  in  1  head reads rs3 = inst[31:27]
out_valid  out  1  head entry valid
out_pc  out  ADDR_WIDTH  head pc
out_pc4  out  ADDR_WIDTH  head pc4
out_inst  out  INST_WIDTH  head instruction
load_stall  out  1  head blocked by load-use hazard
pop  out  1  head consumed this cycle
count  out  $clog2(DEPTH+1)  occupancy
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Reset (reset==0, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Storage array is not reset.
  - Resulting outputs: out_valid=0, in_ready=1, empty=1, full=0, load_stall=0, pop=0, out_pc/out_pc4/out_inst=0.
- Reset release: the queue accepts on the first rising edge with reset==1.
- Ready: in_ready = !full. It does not depend on pop, so there is no combinational in->out path. A full queue refuses an entry even while popping.
- Push: push = in_valid & in_ready & !flush. The entry is written at wr_ptr. wr_ptr advances, wrapping from DEPTH-1 to 0 by explicit compare, not modulo.
- Head:
  - out_valid = !empty.
  - out_* read combinationally from entry rd_ptr, masked to 0 when empty.
  - A pushed entry is visible at the head the cycle after the push edge. There is no same-cycle bypass. Latency is 1 cycle into an empty queue.
- Hazard: load_stall = out_valid & is_load & (load_rd != 0) & ((has_rs1 & rs1==load_rd) | (has_rs2 & rs2==load_rd) | (has_rs3 & rs3==load_rd)).
  - Combinational.
  - load_rd==0 never stalls.
- Pop: pop = out_valid & !stall & !load_stall & !flush. rd_ptr advances with the same wrap rule as wr_ptr.
- Count: next count = count + push - pop.
  - Simultaneous push and pop leave count unchanged.
  - Push and pop together are only possible when count is between 1 and DEPTH-1.
- Flush:
  - On the edge with flush=1: rd_ptr=wr_ptr=0, count=0.
  - The same-cycle push is dropped and pop is forced 0.
  - The next cycle shows out_valid=0.
  - flush outranks stall and load_stall.
- Stall with a non-full queue: the head holds, pushes continue until full, and the entry order is preserved.
- Registered state is rd_ptr, wr_ptr, count and the storage. All other outputs are combinational from that state.
- Assertions (bench):
  - count <= DEPTH always.
  - No push when full.
  - No pop when empty.

Test Plan:
1. Reset then fill (DEPTH=4): push pc=0x100,0x104,0x108,0x10C with stall=1 -> count 1..4, full=1 and in_ready=0 after the 4th. A 5th in_valid is refused and count stays 4.
2. Drain in order: from test 1, drop stall -> out_pc is 0x100,0x104,0x108,0x10C on successive cycles, then empty=1 and out_pc=0.
3. Load-use: head inst with rs1=5, has_rs1=1, is_load=1, load_rd=5 -> load_stall=1, pop=0, head held. Next cycle is_load=0 -> pop=1. Repeat with load_rd=0 -> no stall.
4. Simultaneous push/pop at count=2 for 10 cycles with pc incrementing by 4 -> count stays 2, outputs strictly ordered, pointers wrap past entry 3 (also run DEPTH=3 to exercise the non-power-of-two wrap).
5. Flush with in_valid=1 and count=3 -> next cycle count=0, out_valid=0. The flushed-cycle entry is absent. The next push appears at the head one cycle later.
6. Asynchronous reset mid-operation: assert reset=0 between clock edges with count=3 -> count=0, out_valid=0, in_ready=1 immediately, without waiting for a clock edge.
